// File: rtl/lcd_text_refresher_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lcd_text_refresher_pkg: LCD command codes and FSM state types    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package lcd_text_refresher_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h28;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    typedef enum logic [3:0] {
        ST_PWR_WAIT,
        ST_N3A,
        ST_N3B,
        ST_N3C,
        ST_N2,
        ST_FUNC_SET,
        ST_ENTRY,
        ST_DISP_ON,
        ST_CLEAR,
        ST_FRAME_START,
        ST_ADDR1,
        ST_LINE1,
        ST_ADDR2,
        ST_LINE2,
        ST_FRAME_END
    } top_state_e;

    typedef enum logic [2:0] {
        BW_IDLE,
        BW_SETUP_HI,
        BW_E_HI,
        BW_GAP,
        BW_SETUP_LO,
        BW_E_LO,
        BW_POST
    } bw_state_e;

endpackage
`default_nettype wire

// File: rtl/lcd_text_refresher_byte_writer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lcd_byte_writer: one HD44780 byte or nibble write plus post-delay|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module lcd_byte_writer
    import lcd_text_refresher_pkg::*;
#(
    parameter int T_E       = 12,
    parameter int T_SETUP   = 2,
    parameter int T_NIB_GAP = 50,
    parameter int CNT_W     = 20
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iStart,
    input  logic [7:0]       iByte,
    input  logic             iRS,
    input  logic             iNibbleOnly,
    input  logic [CNT_W-1:0] iPostDelay,
    output logic             oDone,
    output logic             oLCD_E,
    output logic             oLCD_RS,
    output logic [3:0]       oSF_DATA
);

    localparam logic [CNT_W-1:0] C_E_LAST     = CNT_W'(T_E - 1);
    localparam logic [CNT_W-1:0] C_SETUP_LAST = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST   = CNT_W'(T_NIB_GAP - 1);

    bw_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] post_q, post_d;
    logic [7:0]       byte_q, byte_d;
    logic             rs_q, rs_d;
    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= BW_IDLE;
            cnt_q   <= '0;
            post_q  <= '0;
            byte_q  <= '0;
            rs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            post_q  <= post_d;
            byte_q  <= byte_d;
            rs_q    <= rs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
        post_d  = post_q;
        byte_d  = byte_q;
        rs_d    = rs_q;
        case (state_q)
            BW_IDLE: begin
                cnt_d = cnt_q;
                if (iStart) begin
                    byte_d  = iByte;
                    rs_d    = iRS;
                    post_d  = iPostDelay - CNT_W'(1);
                    cnt_d   = C_SETUP_LAST;
                    // A nibble-only write goes out on the lower-nibble path
                    state_d = iNibbleOnly ? BW_SETUP_LO : BW_SETUP_HI;
                end
            end
            BW_SETUP_HI: if (cnt_zero) begin state_d = BW_E_HI;     cnt_d = C_E_LAST;     end
            BW_E_HI:     if (cnt_zero) begin state_d = BW_GAP;      cnt_d = C_GAP_LAST;   end
            BW_GAP:      if (cnt_zero) begin state_d = BW_SETUP_LO; cnt_d = C_SETUP_LAST; end
            BW_SETUP_LO: if (cnt_zero) begin state_d = BW_E_LO;     cnt_d = C_E_LAST;     end
            BW_E_LO:     if (cnt_zero) begin state_d = BW_POST;     cnt_d = post_q;       end
            BW_POST:     if (cnt_zero) state_d = BW_IDLE;
            default:     state_d = BW_IDLE;
        endcase
    end

    always_comb begin
        oDone    = (state_q == BW_POST) && cnt_zero;
        oLCD_E   = (state_q == BW_E_HI) || (state_q == BW_E_LO);
        oLCD_RS  = (state_q != BW_IDLE) ? rs_q : 1'b0;
        oSF_DATA = 4'h0;
        case (state_q)
            BW_SETUP_HI, BW_E_HI, BW_GAP:  oSF_DATA = byte_q[7:4];
            BW_SETUP_LO, BW_E_LO, BW_POST: oSF_DATA = byte_q[3:0];
            default:                       oSF_DATA = 4'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lcd_text_refresher.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lcd_text_refresher: inits the character LCD, repaints 2x16 chars |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module lcd_text_refresher
    import lcd_text_refresher_pkg::*;
#(
    parameter int T_POWERUP = 750000,
    parameter int T_INIT1   = 205000,
    parameter int T_INIT2   = 5000,
    parameter int T_CMD     = 2000,
    parameter int T_CLEAR   = 82000,
    parameter int T_E       = 12,
    parameter int T_SETUP   = 2,
    parameter int T_NIB_GAP = 50,
    parameter int CNT_W     = 20
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [255:0] iChars,
    output logic         oLCD_E,
    output logic         oLCD_RS,
    output logic         oLCD_RW,
    output logic [3:0]   oSF_DATA,
    output logic         oReady,
    output logic         oFrameDone
);

    localparam logic [CNT_W-1:0] C_PWR_LAST = CNT_W'(T_POWERUP - 1);
    localparam logic [CNT_W-1:0] C_INIT1    = CNT_W'(T_INIT1);
    localparam logic [CNT_W-1:0] C_INIT2    = CNT_W'(T_INIT2);
    localparam logic [CNT_W-1:0] C_CMD      = CNT_W'(T_CMD);
    localparam logic [CNT_W-1:0] C_CLEAR    = CNT_W'(T_CLEAR);

    top_state_e       state_q, state_d;
    logic [CNT_W-1:0] pwr_q, pwr_d;
    logic [4:0]       idx_q, idx_d;
    logic [255:0]     snap_q, snap_d;
    logic [7:0]       char_sel;

    logic             wr_start, wr_rs, wr_nib, wr_done;
    logic [7:0]       wr_byte;
    logic [CNT_W-1:0] wr_post;

    // Char i sits at bits [(31-i)*8 +: 8]; 31-i is the bitwise inverse of a 5-bit i
    assign char_sel = {~idx_q, 3'b000};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_PWR_WAIT;
            pwr_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            pwr_q   <= pwr_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pwr_d   = pwr_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        case (state_q)
            ST_PWR_WAIT: begin
                if (pwr_q == C_PWR_LAST) state_d = ST_N3A;
                else                     pwr_d   = pwr_q + CNT_W'(1);
            end
            ST_N3A:      if (wr_done) state_d = ST_N3B;
            ST_N3B:      if (wr_done) state_d = ST_N3C;
            ST_N3C:      if (wr_done) state_d = ST_N2;
            ST_N2:       if (wr_done) state_d = ST_FUNC_SET;
            ST_FUNC_SET: if (wr_done) state_d = ST_ENTRY;
            ST_ENTRY:    if (wr_done) state_d = ST_DISP_ON;
            ST_DISP_ON:  if (wr_done) state_d = ST_CLEAR;
            ST_CLEAR:    if (wr_done) state_d = ST_FRAME_START;
            ST_FRAME_START: begin
                snap_d  = iChars;
                idx_d   = 5'd0;
                state_d = ST_ADDR1;
            end
            ST_ADDR1:    if (wr_done) state_d = ST_LINE1;
            ST_LINE1: begin
                if (wr_done) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == 5'd15) state_d = ST_ADDR2;
                end
            end
            ST_ADDR2:    if (wr_done) state_d = ST_LINE2;
            ST_LINE2: begin
                if (wr_done) begin
                    if (idx_q == 5'd31) begin
                        idx_d   = 5'd0;
                        state_d = ST_FRAME_END;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                    end
                end
            end
            ST_FRAME_END: state_d = ST_FRAME_START;
            default:      state_d = ST_PWR_WAIT;
        endcase
    end

    // Start is held for the whole write state; the writer only accepts it when idle
    always_comb begin
        wr_start   = 1'b0;
        wr_byte    = 8'h00;
        wr_rs      = 1'b0;
        wr_nib     = 1'b0;
        wr_post    = C_CMD;
        oFrameDone = (state_q == ST_FRAME_END);
        oReady     = (state_q inside {ST_FRAME_START, ST_ADDR1, ST_LINE1,
                                      ST_ADDR2, ST_LINE2, ST_FRAME_END});
        case (state_q)
            ST_N3A:      begin wr_start = 1'b1; wr_nib = 1'b1; wr_byte = 8'h03; wr_post = C_INIT1; end
            ST_N3B:      begin wr_start = 1'b1; wr_nib = 1'b1; wr_byte = 8'h03; wr_post = C_INIT2; end
            ST_N3C:      begin wr_start = 1'b1; wr_nib = 1'b1; wr_byte = 8'h03; end
            ST_N2:       begin wr_start = 1'b1; wr_nib = 1'b1; wr_byte = 8'h02; end
            ST_FUNC_SET: begin wr_start = 1'b1; wr_byte = LCD_FUNC_SET; end
            ST_ENTRY:    begin wr_start = 1'b1; wr_byte = LCD_ENTRY;    end
            ST_DISP_ON:  begin wr_start = 1'b1; wr_byte = LCD_DISP_ON;  end
            ST_CLEAR:    begin wr_start = 1'b1; wr_byte = LCD_CLEAR; wr_post = C_CLEAR; end
            ST_ADDR1:    begin wr_start = 1'b1; wr_byte = LCD_LINE1;    end
            ST_ADDR2:    begin wr_start = 1'b1; wr_byte = LCD_LINE2;    end
            ST_LINE1, ST_LINE2: begin
                wr_start = 1'b1;
                wr_rs    = 1'b1;
                wr_byte  = snap_q[char_sel +: 8];
            end
            default: wr_start = 1'b0;
        endcase
    end

    lcd_byte_writer #(
        .T_E       (T_E),
        .T_SETUP   (T_SETUP),
        .T_NIB_GAP (T_NIB_GAP),
        .CNT_W     (CNT_W)
    ) u_writer (
        .Clock       (Clock),
        .Reset       (Reset),
        .iStart      (wr_start),
        .iByte       (wr_byte),
        .iRS         (wr_rs),
        .iNibbleOnly (wr_nib),
        .iPostDelay  (wr_post),
        .oDone       (wr_done),
        .oLCD_E      (oLCD_E),
        .oLCD_RS     (oLCD_RS),
        .oSF_DATA    (oSF_DATA)
    );

    assign oLCD_RW = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_refresher.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_lcd_text_refresher: decodes the LCD bus and checks init/frames|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_lcd_text_refresher;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic [255:0] iChars;
    logic         oLCD_E, oLCD_RS, oLCD_RW, oReady, oFrameDone;
    logic [3:0]   oSF_DATA;

    always #5 Clock = ~Clock;

    lcd_text_refresher #(
        .T_POWERUP (100),
        .T_INIT1   (40),
        .T_INIT2   (20),
        .T_CMD     (10),
        .T_CLEAR   (30),
        .T_E       (3),
        .T_SETUP   (1),
        .T_NIB_GAP (2),
        .CNT_W     (20)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .iChars     (iChars),
        .oLCD_E     (oLCD_E),
        .oLCD_RS    (oLCD_RS),
        .oLCD_RW    (oLCD_RW),
        .oSF_DATA   (oSF_DATA),
        .oReady     (oReady),
        .oFrameDone (oFrameDone)
    );

    typedef struct {
        logic       rs;
        logic [3:0] nib;
        int         t;
    } nib_t;

    nib_t nq[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic       e_prev = 1'b0, e_rs = 1'b0, p_rs = 1'b0, fd_prev = 1'b0, rdy_prev = 1'b0;
    logic       mon_en = 1'b1, rdy_seen = 1'b0;
    logic [3:0] e_dat = 4'h0, p_dat = 4'h0;
    int         e_w = 0, rdy_cyc = 0;
    int         rw_viol = 0, width_viol = 0, stab_viol = 0, setup_viol = 0, hold_viol = 0;
    int         fd_cnt = 0, fd_high = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    // Bus monitor: records every E pulse and tallies timing/stability violations
    always @(negedge Clock) begin
        if (oLCD_RW !== 1'b0) rw_viol <= rw_viol + 1;
        if (oLCD_E === 1'b1) begin
            if (!e_prev) begin
                nq.push_back('{oLCD_RS, oSF_DATA, cyc});
                if (mon_en && (oLCD_RS !== p_rs || oSF_DATA !== p_dat)) setup_viol <= setup_viol + 1;
                e_rs <= oLCD_RS;
                e_dat <= oSF_DATA;
                e_w <= 1;
            end else begin
                e_w <= e_w + 1;
                if (mon_en && (oLCD_RS !== e_rs || oSF_DATA !== e_dat)) stab_viol <= stab_viol + 1;
            end
        end else if (e_prev && mon_en) begin
            if (e_w != 3) width_viol <= width_viol + 1;
            if (oLCD_RS !== e_rs || oSF_DATA !== e_dat) hold_viol <= hold_viol + 1;
        end
        if (oFrameDone === 1'b1) fd_high <= fd_high + 1;
        if (oFrameDone === 1'b1 && !fd_prev) fd_cnt <= fd_cnt + 1;
        if (oReady === 1'b1 && !rdy_prev) begin
            rdy_cyc <= cyc;
            rdy_seen <= 1'b1;
        end
        e_prev   <= (oLCD_E === 1'b1);
        fd_prev  <= (oFrameDone === 1'b1);
        rdy_prev <= (oReady === 1'b1);
        p_rs     <= oLCD_RS;
        p_dat    <= oSF_DATA;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_nibs(input int n);
        int k;
        k = 0;
        while (nq.size() < n && k < 3000) begin
            @(negedge Clock);
            k++;
        end
        check("wait_nibs", 128'(nq.size() >= n), 128'(1));
    endtask

    function automatic logic [7:0] byte_at(input int k);
        return {nq[k].nib, nq[k+1].nib};
    endfunction

    task automatic check_frame(input string tag, input int base, input logic [255:0] exp);
        int           err;
        logic [127:0] l1, l2;
        logic [7:0]   b;
        logic         rs;
        err = 0;
        l1  = '0;
        l2  = '0;
        for (int j = 0; j < 34; j++) begin
            b  = byte_at(base + 2*j);
            rs = nq[base + 2*j].rs;
            if (nq[base + 2*j + 1].rs !== rs) err++;
            if (j == 0) begin
                if (b !== 8'h80 || rs !== 1'b0) err++;
            end else if (j == 17) begin
                if (b !== 8'hC0 || rs !== 1'b0) err++;
            end else begin
                if (rs !== 1'b1) err++;
                if (j < 17) l1 = {l1[119:0], b};
                else        l2 = {l2[119:0], b};
            end
        end
        check({tag, "_ctl"}, 128'(err), 128'(0));
        check({tag, "_line1"}, l1, exp[255:128]);
        check({tag, "_line2"}, l2, exp[127:0]);
    endtask

    task automatic check_init(input string tag, input int rel);
        check({tag, "_nibs"}, {nq[0].nib, nq[1].nib, nq[2].nib, nq[3].nib}, 128'h3332);
        check({tag, "_rs"}, 128'(nq[0].rs | nq[1].rs | nq[2].rs | nq[3].rs), 128'(0));
        check({tag, "_pwr"}, 128'((nq[0].t - rel) >= 100), 128'(1));
        check({tag, "_gaps"}, 128'(((nq[1].t - nq[0].t - 3) >= 40) &&
                                   ((nq[2].t - nq[1].t - 3) >= 20) &&
                                   ((nq[3].t - nq[2].t - 3) >= 10)), 128'(1));
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_e"},  128'(oLCD_E),     128'(0));
        check({tag, "_rs"}, 128'(oLCD_RS),    128'(0));
        check({tag, "_d"},  128'(oSF_DATA),   128'(0));
        check({tag, "_rdy"},128'(oReady),     128'(0));
        check({tag, "_fd"}, 128'(oFrameDone), 128'(0));
    endtask

    logic [255:0] str1, str2;
    int           rel, k;

    initial begin
        str1   = "Atrapa al Topo!!Score: 00 Lvl: 1";
        str2   = "Atrapa al Topo!!Score: 07 Lvl: 1";
        iChars = str1;
        Reset  = 1'b1;
        repeat (3) @(negedge Clock);
        check_reset_outs("rst0");
        Reset = 1'b0;
        rel   = cyc;

        wait_nibs(4);
        check_init("init0", rel);

        wait_nibs(12);
        check("cmd_bytes", {byte_at(4), byte_at(6), byte_at(8), byte_at(10)}, 128'h28060C01);
        check("cmd_rs", 128'(nq[4].rs | nq[5].rs | nq[6].rs | nq[7].rs |
                             nq[8].rs | nq[9].rs | nq[10].rs | nq[11].rs), 128'(0));
        check("rdy_early", 128'(oReady), 128'(0));
        k = 0;
        while (!rdy_seen && k < 200) begin
            @(negedge Clock);
            k++;
        end
        check("rdy_up", 128'(oReady), 128'(1));
        check("rdy_gap", 128'(rdy_seen && (rdy_cyc - nq[10].t) >= 33), 128'(1));

        // Change the score while frame 1 is painting line 1
        wait_nibs(24);
        iChars = str2;

        wait_nibs(12 + 68 + 1);
        check("fd_one", 128'(fd_cnt), 128'(1));
        check_frame("f1", 12, str1);

        wait_nibs(12 + 68*3 + 1);
        check_frame("f2", 12 + 68, str2);
        check_frame("f3", 12 + 68*2, str2);
        check("fd_three", 128'(fd_cnt), 128'(3));
        check("fd_width", 128'(fd_high), 128'(3));

        // Reset in the middle of an E pulse during line 2 of frame 4
        wait_nibs(12 + 68*3 + 40);
        k = 0;
        while (oLCD_E !== 1'b1 && k < 100) begin
            @(negedge Clock);
            k++;
        end
        check("e_found", 128'(oLCD_E), 128'(1));
        mon_en = 1'b0;
        Reset  = 1'b1;
        @(negedge Clock);
        check_reset_outs("rst1");
        Reset = 1'b0;
        rel   = cyc;
        nq.delete();
        @(negedge Clock);
        mon_en = 1'b1;
        wait_nibs(4);
        check_init("init1", rel);

        check("rw_viol", 128'(rw_viol), 128'(0));
        check("width_viol", 128'(width_viol), 128'(0));
        check("stab_viol", 128'(stab_viol), 128'(0));
        check("setup_viol", 128'(setup_viol), 128'(0));
        check("hold_viol", 128'(hold_viol), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
